// File: rtl/audio_pkg.sv
// Shared types for the audio mixer: FSM state encoding and the default sample type.
// No logic, no latency.
// No backpressure; types only.
package audio_pkg;

  // Default sample width used by the audio block
  localparam int AUDIO_SAMPLE_W = 16;

  // Signed PCM sample at the default width
  typedef logic signed [AUDIO_SAMPLE_W-1:0] sample_t;

  // Mixer sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    SUM     = 2'd2,
    PRESENT = 2'd3
  } mix_state_t;

endpackage

// File: rtl/audio_mix_reduce.sv
// Reduces a wide signed accumulator to one output sample per channel.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller captures the result when it needs it.
// Build option AUDIO_MIX_SATURATE_EN: clamp at full gain; otherwise arithmetic shift by VW.
module audio_mix_reduce
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = AUDIO_SAMPLE_W,
  parameter int VW       = 2
) (
  input  logic signed [SAMPLE_W+VW-1:0] acc_l_i,
  input  logic signed [SAMPLE_W+VW-1:0] acc_r_i,
  output logic signed [SAMPLE_W-1:0]    smp_l_o,
  output logic signed [SAMPLE_W-1:0]    smp_r_o
);

  localparam int AW = SAMPLE_W + VW;

`ifdef AUDIO_MIX_SATURATE_EN
  // Largest and smallest values representable in the output sample width
  localparam logic signed [AW-1:0] SAT_MAX = {{(VW+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(VW+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  // Full per-voice gain; any excursion beyond the output range is clipped
  function automatic logic signed [SAMPLE_W-1:0] reduce_one(input logic signed [AW-1:0] acc);
    if (acc > SAT_MAX) begin
      return SAMPLE_W'(SAT_MAX);
    end else if (acc < SAT_MIN) begin
      return SAMPLE_W'(SAT_MIN);
    end else begin
      return SAMPLE_W'(acc);
    end
  endfunction
`else
  // Uniform attenuation by VOICES: a sum of VOICES full-scale samples always fits
  function automatic logic signed [SAMPLE_W-1:0] reduce_one(input logic signed [AW-1:0] acc);
    return SAMPLE_W'(acc >>> VW);
  endfunction
`endif

  // Both channels share the same reduction rule
  always_comb begin
    smp_l_o = reduce_one(acc_l_i);
    smp_r_o = reduce_one(acc_r_i);
  end

endmodule

// File: rtl/audio_mix_scheduler.sv
// Per frame request, polls each enabled voice in turn, sums L/R, presents one mixed stereo frame.
// Latency: with immediate acks, out_frame_valid rises VOICES+2 cycles after the request edge.
// Backpressure: frame held stable while valid && !ready; requests outside IDLE are dropped (underrun).
// Build option AUDIO_MIX_SATURATE_EN selects clamping instead of attenuation (see audio_mix_reduce).
module audio_mix_scheduler
  import audio_pkg::*;
#(
  parameter  int VOICES   = 4,
  parameter  int SAMPLE_W = AUDIO_SAMPLE_W,
  parameter  int TIMEOUT  = 255,
  localparam int VW       = $clog2(VOICES)
) (
  input  logic                       inp_clock,
  input  logic                       inp_reset,
  input  logic                       inp_frame_req,
  input  logic [VOICES-1:0]          inp_voice_mask,
  output logic [VW-1:0]              out_voice_sel,
  output logic                       out_voice_req,
  input  logic                       inp_voice_ack,
  input  logic signed [SAMPLE_W-1:0] inp_voice_left,
  input  logic signed [SAMPLE_W-1:0] inp_voice_right,
  output logic                       out_frame_valid,
  input  logic                       inp_frame_ready,
  output logic signed [SAMPLE_W-1:0] out_frame_left,
  output logic signed [SAMPLE_W-1:0] out_frame_right,
  output logic                       out_busy,
  output logic                       out_underrun,
  output logic                       out_timeout
);

  localparam int AW = SAMPLE_W + VW;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [VW-1:0] LAST_SEL = VW'(VOICES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  mix_state_t                 state_q, state_d;
  logic [VW-1:0]              sel_q, sel_d;
  logic [VOICES-1:0]          mask_q, mask_d;
  logic [TW-1:0]              tcnt_q, tcnt_d;
  logic signed [AW-1:0]       acc_l_q, acc_l_d;
  logic signed [AW-1:0]       acc_r_q, acc_r_d;
  logic signed [SAMPLE_W-1:0] frame_l_q, frame_l_d;
  logic signed [SAMPLE_W-1:0] frame_r_q, frame_r_d;
  logic                       underrun_q, underrun_d;
  logic                       timeout_q, timeout_d;

  logic                       voice_en;
  logic                       slot_done;
  logic signed [AW-1:0]       ext_l, ext_r;
  logic signed [SAMPLE_W-1:0] red_l, red_r;

  // Mask is latched at frame start so mid-frame mask changes wait for the next frame
  assign voice_en = mask_q[sel_q];

  // Sign-extend the incoming voice samples to accumulator width
  assign ext_l = AW'(inp_voice_left);
  assign ext_r = AW'(inp_voice_right);

  audio_mix_reduce #(
    .SAMPLE_W (SAMPLE_W),
    .VW       (VW)
  ) u_reduce (
    .acc_l_i (acc_l_q),
    .acc_r_i (acc_r_q),
    .smp_l_o (red_l),
    .smp_r_o (red_r)
  );

  // Next-state logic: frame sequencing, voice slots, timeout and underrun detection
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    mask_d     = mask_q;
    tcnt_d     = tcnt_q;
    acc_l_d    = acc_l_q;
    acc_r_d    = acc_r_q;
    frame_l_d  = frame_l_q;
    frame_r_d  = frame_r_q;
    timeout_d  = 1'b0;
    slot_done  = 1'b0;
    // Any request not taken in IDLE is lost, including one on the PRESENT->IDLE edge
    underrun_d = inp_frame_req && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (inp_frame_req) begin
          state_d = FETCH;
          sel_d   = '0;
          mask_d  = inp_voice_mask;
          tcnt_d  = '0;
          acc_l_d = '0;
          acc_r_d = '0;
        end
      end

      FETCH: begin
        if (!voice_en) begin
          // Disabled voice: one idle cycle, contributes nothing
          slot_done = 1'b1;
        end else if (inp_voice_ack) begin
          // Transfer happens on the req&ack cycle; an ack on the final allowed cycle still counts
          acc_l_d   = acc_l_q + ext_l;
          acc_r_d   = acc_r_q + ext_r;
          slot_done = 1'b1;
        end else if (tcnt_q == TO_LAST) begin
          // Silent voice: substitute zero and move on so the frame still completes
          timeout_d = 1'b1;
          slot_done = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end

        if (slot_done) begin
          tcnt_d = '0;
          if (sel_q == LAST_SEL) begin
            state_d = SUM;
          end else begin
            sel_d = sel_q + VW'(1);
          end
        end
      end

      SUM: begin
        frame_l_d = red_l;
        frame_r_d = red_r;
        state_d   = PRESENT;
      end

      PRESENT: begin
        if (inp_frame_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset clears everything, including a frame in progress
  always_ff @(posedge inp_clock or negedge inp_reset) begin
    if (!inp_reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      mask_q     <= '0;
      tcnt_q     <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      frame_l_q  <= '0;
      frame_r_q  <= '0;
      underrun_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      mask_q     <= mask_d;
      tcnt_q     <= tcnt_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      frame_l_q  <= frame_l_d;
      frame_r_q  <= frame_r_d;
      underrun_q <= underrun_d;
      timeout_q  <= timeout_d;
    end
  end

  // Outputs derive from registered state only, so reset forces them all low at once
  assign out_voice_sel   = sel_q;
  assign out_voice_req   = (state_q == FETCH) && voice_en;
  assign out_frame_valid = (state_q == PRESENT);
  assign out_frame_left  = frame_l_q;
  assign out_frame_right = frame_r_q;
  assign out_busy        = (state_q != IDLE);
  assign out_underrun    = underrun_q;
  assign out_timeout     = timeout_q;

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Self-checking bench for audio_mix_scheduler: directed scenarios plus randomized frames.
// Expected mixes, latencies and pulse counts come from a per-frame arithmetic model.
// Voice producers are emulated by a responder with a per-voice ack delay (negative = never).
module tb_audio_mix_scheduler;
  import audio_pkg::*;

  localparam int NV = 4;
  localparam int SW = 16;
  localparam int TO = 8;

  logic                 inp_clock = 1'b0;
  logic                 inp_reset = 1'b0;
  logic                 inp_frame_req = 1'b0;
  logic [NV-1:0]        inp_voice_mask = '0;
  logic [1:0]           out_voice_sel;
  logic                 out_voice_req;
  logic                 inp_voice_ack;
  logic signed [SW-1:0] inp_voice_left;
  logic signed [SW-1:0] inp_voice_right;
  logic                 out_frame_valid;
  logic                 inp_frame_ready = 1'b0;
  logic signed [SW-1:0] out_frame_left;
  logic signed [SW-1:0] out_frame_right;
  logic                 out_busy;
  logic                 out_underrun;
  logic                 out_timeout;

  int checks = 0;
  int failures = 0;

  // Voice behaviour table and event counters maintained by the responder
  int         vl[NV];
  int         vr[NV];
  int         dly[NV];
  logic [3:0] mask_lat = '0;
  int         n_under = 0;
  int         n_tout = 0;
  int         n_badreq = 0;

  always #5 inp_clock = ~inp_clock;

  audio_mix_scheduler #(
    .VOICES   (NV),
    .SAMPLE_W (SW),
    .TIMEOUT  (TO)
  ) dut (
    .inp_clock       (inp_clock),
    .inp_reset       (inp_reset),
    .inp_frame_req   (inp_frame_req),
    .inp_voice_mask  (inp_voice_mask),
    .out_voice_sel   (out_voice_sel),
    .out_voice_req   (out_voice_req),
    .inp_voice_ack   (inp_voice_ack),
    .inp_voice_left  (inp_voice_left),
    .inp_voice_right (inp_voice_right),
    .out_frame_valid (out_frame_valid),
    .inp_frame_ready (inp_frame_ready),
    .out_frame_left  (out_frame_left),
    .out_frame_right (out_frame_right),
    .out_busy        (out_busy),
    .out_underrun    (out_underrun),
    .out_timeout     (out_timeout)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Mixed output for a given voice sum
  function automatic int mix(input int s);
`ifdef AUDIO_MIX_SATURATE_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    if (s >= 0) return s / NV;
    return -((-s + NV - 1) / NV);
`endif
  endfunction

  // Voice responder: acks the selected voice after its delay; noise on ack/data when not requested
  initial begin
    int         wc;
    logic       last_req;
    logic [1:0] last_sel;
    wc = 0;
    last_req = 1'b0;
    last_sel = '0;
    inp_voice_ack = 1'b0;
    inp_voice_left = '0;
    inp_voice_right = '0;
    forever begin
      @(negedge inp_clock);
      if (out_underrun === 1'b1) n_under++;
      if (out_timeout === 1'b1) n_tout++;
      if (out_voice_req === 1'b1) begin
        if (!mask_lat[out_voice_sel]) n_badreq++;
        if (!last_req || out_voice_sel != last_sel) wc = 0;
        else wc++;
        if (dly[out_voice_sel] >= 0 && wc >= dly[out_voice_sel]) begin
          inp_voice_ack   = 1'b1;
          inp_voice_left  = SW'(vl[out_voice_sel]);
          inp_voice_right = SW'(vr[out_voice_sel]);
        end else begin
          inp_voice_ack   = 1'b0;
          inp_voice_left  = SW'($urandom);
          inp_voice_right = SW'($urandom);
        end
      end else begin
        inp_voice_ack   = 1'($urandom);
        inp_voice_left  = SW'(5000);
        inp_voice_right = SW'(5000);
      end
      last_req = (out_voice_req === 1'b1);
      last_sel = out_voice_sel;
    end
  end

  // One full frame: request, fetch, present with optional backpressure and dropped requests
  task automatic run_frame(input logic [3:0] mask, input bit inj_fetch, input int hold,
                           input bit inj_present, input bit inj_xfer);
    int el, er, ecyc, eto, eu, cyc, u0, t0, b0;
    el = 0; er = 0; ecyc = 2; eto = 0;
    for (int i = 0; i < NV; i++) begin
      if (mask[i]) begin
        if (dly[i] >= 0 && dly[i] < TO) begin
          el += vl[i];
          er += vr[i];
          ecyc += dly[i] + 1;
        end else begin
          eto++;
          ecyc += TO;
        end
      end else begin
        ecyc += 1;
      end
    end
    el = mix(el);
    er = mix(er);
    eu = int'(inj_fetch) + int'(inj_present && hold >= 2) + int'(inj_xfer);
    u0 = n_under; t0 = n_tout; b0 = n_badreq;

    @(negedge inp_clock);
    inp_frame_req  = 1'b1;
    inp_voice_mask = mask;
    mask_lat       = mask;
    @(negedge inp_clock);
    cyc = 1;
    inp_frame_req  = 1'b0;
    inp_voice_mask = ~mask;
    check("busy_at_start", out_busy, 1);
    while (out_frame_valid !== 1'b1 && cyc < 400) begin
      if (inj_fetch && cyc == 2) inp_frame_req = 1'b1;
      else inp_frame_req = 1'b0;
      @(negedge inp_clock);
      cyc++;
    end
    inp_frame_req = 1'b0;
    check("valid_cycle", cyc, ecyc);
    check("frame_left", out_frame_left, el);
    check("frame_right", out_frame_right, er);

    for (int h = 0; h < hold; h++) begin
      inp_frame_req = (inj_present && h == 1);
      @(negedge inp_clock);
      check("hold_valid", out_frame_valid, 1);
      check("hold_left", out_frame_left, el);
      check("hold_right", out_frame_right, er);
    end

    inp_frame_ready = 1'b1;
    inp_frame_req   = inj_xfer;
    @(negedge inp_clock);
    inp_frame_ready = 1'b0;
    inp_frame_req   = 1'b0;
    check("valid_dropped", out_frame_valid, 0);
    check("idle_after_xfer", out_busy, 0);
    check("held_left", out_frame_left, el);
    check("held_right", out_frame_right, er);
    repeat (3) @(negedge inp_clock);
    check("no_extra_frame", out_busy, 0);
    check("underrun_pulses", n_under - u0, eu);
    check("timeout_pulses", n_tout - t0, eto);
    check("req_on_masked", n_badreq - b0, 0);
  endtask

  task automatic set_voices(input int l0, input int l1, input int l2, input int l3);
    vl[0] = l0; vl[1] = l1; vl[2] = l2; vl[3] = l3;
    for (int i = 0; i < NV; i++) begin
      vr[i]  = -vl[i];
      dly[i] = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_voices(0, 0, 0, 0);

    // Reset state
    #12;
    check("rst_valid", out_frame_valid, 0);
    check("rst_busy", out_busy, 0);
    check("rst_req", out_voice_req, 0);
    check("rst_sel", out_voice_sel, 0);
    check("rst_left", out_frame_left, 0);
    check("rst_right", out_frame_right, 0);
    check("rst_underrun", out_underrun, 0);
    check("rst_timeout", out_timeout, 0);
    @(negedge inp_clock);
    inp_reset = 1'b1;
    repeat (2) @(negedge inp_clock);

    // Basic mix
    set_voices(100, 200, 300, 400);
    run_frame(4'b1111, 0, 0, 0, 0);

    // Full-scale voices
    for (int i = 0; i < NV; i++) begin
      vl[i] = 32767; vr[i] = -32768; dly[i] = 0;
    end
    run_frame(4'b1111, 0, 1, 0, 0);

    // Masking: voice 1 would add 5000 if it were polled
    set_voices(1234, 5000, -777, 9999);
    run_frame(4'b0101, 0, 0, 0, 0);

    // Timeout on voice 2, plus the last-cycle ack boundary on voice 3
    set_voices(400, -800, 1600, 3200);
    dly[2] = -1;
    dly[3] = TO - 1;
    run_frame(4'b1111, 0, 0, 0, 0);
    dly[2] = TO;
    dly[3] = 0;
    run_frame(4'b1100, 0, 0, 0, 0);

    // Underrun during FETCH, during PRESENT backpressure, and on the transfer cycle
    set_voices(-3000, 1500, 2500, -6000);
    run_frame(4'b1111, 1, 10, 1, 1);

    // Reset in the middle of fetching voice 1
    set_voices(111, 222, 333, 444);
    dly[1] = 5;
    mask_lat = 4'b1111;
    @(negedge inp_clock);
    inp_frame_req  = 1'b1;
    inp_voice_mask = 4'b1111;
    @(negedge inp_clock);
    inp_frame_req = 1'b0;
    @(negedge inp_clock);
    check("mid_sel", out_voice_sel, 1);
    check("mid_req", out_voice_req, 1);
    #2;
    inp_reset = 1'b0;
    #1;
    check("arst_req", out_voice_req, 0);
    check("arst_sel", out_voice_sel, 0);
    check("arst_busy", out_busy, 0);
    check("arst_valid", out_frame_valid, 0);
    check("arst_left", out_frame_left, 0);
    check("arst_right", out_frame_right, 0);
    repeat (2) @(negedge inp_clock);
    inp_reset = 1'b1;
    @(negedge inp_clock);
    set_voices(10, 20, 30, 40);
    run_frame(4'b1111, 0, 0, 0, 0);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int  r, hold;
      logic [3:0] m;
      m = 4'($urandom);
      for (int i = 0; i < NV; i++) begin
        vl[i] = int'($urandom_range(0, 65535)) - 32768;
        vr[i] = int'($urandom_range(0, 65535)) - 32768;
        r = int'($urandom_range(0, 11));
        if (r < 7) dly[i] = 0;
        else if (r < 9) dly[i] = int'($urandom_range(1, 4));
        else if (r == 9) dly[i] = TO - 1;
        else if (r == 10) dly[i] = TO;
        else dly[i] = -1;
      end
      hold = int'($urandom_range(0, 4));
      run_frame(m, 1'($urandom), hold, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
